uart_cmd_decoder: RTL and testbench
===================================

Name: uart_cmd_decoder

Overview:
- Sits directly downstream of the UART receiver and consumes its byte stream over the rx_req/rx_ready handshake.
- Parses framed binary commands into single register-bus transactions (read or write) for the capture core's control registers.
- Discards noise between frames, aborts frames on line errors or inter-byte timeout, and keeps a saturating error count.

Parameters:
- TIMEOUT_CYCLES, 1000000, max clk cycles between accepted bytes inside a frame before the frame is aborted; >= 2; counter width $clog2(TIMEOUT_CYCLES+1)
- SYNC_BYTE, 8'hA5, frame start marker

Ports:
- clk  input  1  system clock
- reset_  input  1  synchronous, active-low reset
- rx_req  input  1  byte available from UART receiver; held until acknowledged
- rx_ready  output  1  byte acknowledge; a byte is consumed in any cycle with rx_req && rx_ready
- rx_data  input  8  received byte, valid while rx_req
- rx_error  input  1  stop-bit error flag for rx_data, valid while rx_req
- cmd_valid  output  1  command available; held until cmd_ready
- cmd_ready  input  1  command consumer accept
- cmd_write  output  1  1 = write, 0 = read
- cmd_addr  output  8  register address
- cmd_wdata  output  32  write data (0 for reads)
- err_cnt  output  8  saturating count of aborted/rejected frames

Behaviour:
- One clock, synchronous active-low reset (reset_ sampled on posedge clk). Reset values: state IDLE, cmd_valid 0, cmd_write 0, cmd_addr 0, cmd_wdata 0, err_cnt 0, timeout counter 0. Reset mid-frame or mid-issue drops everything; no command issued.
- rx_ready is combinational: 1 in every state except ISSUE. No other inputs gate it.
- Frame format: SYNC_BYTE, CMD, ADDR, then for writes 4 data bytes LSB first. CMD 8'h57 ('W') = write, 8'h52 ('R') = read.
- State machine (transitions occur on accepted bytes unless noted):
  - IDLE: byte == SYNC_BYTE with rx_error 0 -> CMD. Any other byte, or any byte with rx_error set, is discarded silently (no err_cnt change).
  - CMD: 'W' -> ADDR with write flag set; 'R' -> ADDR with write flag clear; any other value -> IDLE, err_cnt+1.
  - ADDR: latch addr. Write -> DATA with byte_idx = 0. Read -> ISSUE (CSUM if enabled).
  - DATA: byte_idx selects the wdata lane, [8*i +: 8]. byte_idx 3 -> ISSUE (CSUM if enabled); otherwise byte_idx+1.
  - ISSUE: cmd_valid = 1. On cmd_valid && cmd_ready -> IDLE, and cmd_valid = 0 next cycle. Outputs stay stable while waiting. Bytes are back-pressured, never dropped.
- Read commands present cmd_wdata = 0.
- Latency: cmd_valid rises the cycle after the last frame byte is accepted.
- rx_error on an accepted byte in CMD/ADDR/DATA/CSUM -> IDLE, err_cnt+1. The byte is not used, even if it equals SYNC_BYTE.
- A SYNC_BYTE received mid-frame is treated as ordinary data (no resync).
- Timeout:
  - The counter runs only in CMD/ADDR/DATA/CSUM and clears on every accepted byte and on entry to IDLE.
  - Counter reaching TIMEOUT_CYCLES -> IDLE, err_cnt+1.
  - If a byte is accepted in the same cycle the counter expires, the byte wins and the counter clears.
- err_cnt saturates at 8'hFF and clears only on reset. At most one increment per cycle.

Optional Feature:
- Macro CMD_CHECKSUM_EN.
- Defined:
  - Adds a CSUM state after ADDR (reads) or the 4th DATA byte (writes).
  - Expected byte = XOR of CMD, ADDR and all data bytes; the running XOR clears on entry to CMD.
  - Match -> ISSUE. Mismatch -> IDLE, err_cnt+1, no command.
  - The timeout and rx_error rules apply to the CSUM state.
- Undefined: no CSUM state and no checksum logic; frames end at the last ADDR/DATA byte.

Test Plan:
- Bytes A5 57 10 EF BE AD DE, cmd_ready=1 -> one cmd_valid pulse: cmd_write=1, cmd_addr=8'h10, cmd_wdata=32'hDEADBEEF, err_cnt=0.
- Bytes 00 33 A5 52 04, cmd_ready held 0 for 20 cycles -> cmd_valid held with write=0, addr=8'h04, wdata=0. rx_ready=0 throughout; a pending 0x55 from the receiver is not consumed until the cycle after cmd_ready rises.
- Bytes A5 58 -> no command, err_cnt=1. Then a valid read frame A5 52 07 -> command issued with addr 8'h07.
- TIMEOUT_CYCLES=50: A5 57 then 50 idle cycles -> IDLE, err_cnt=1. The following A5 57 01 01 00 00 00 -> write addr 01, data 32'h00000001.
- A5 57 with rx_error=1 on the ADDR byte -> abort, err_cnt=1. 300 bad CMD frames -> err_cnt=8'hFF. Reset asserted mid-frame -> err_cnt=0, cmd_valid=0, and the next frame decodes correctly.
- With CMD_CHECKSUM_EN: A5 52 04 56 (56 = 52^04) -> read issued. A5 52 04 57 -> dropped, err_cnt=1.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - UART byte-stream to register-bus command decoder
// Optional checksum byte per frame enabled by CMD_CHECKSUM_EN.
module uart_cmd_decoder #(
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        rx_req,
    output logic        rx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_error,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_write,
    output logic [7:0]  cmd_addr,
    output logic [31:0] cmd_wdata,
    output logic [7:0]  err_cnt
);

    localparam int             TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TMO_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [7:0]     CMD_W   = 8'h57;
    localparam logic [7:0]     CMD_R   = 8'h52;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
        S_DATA  = 3'd3,
        S_ISSUE = 3'd4
`ifdef CMD_CHECKSUM_EN
        , S_CSUM = 3'd5
`endif
    } state_t;

`ifdef CMD_CHECKSUM_EN
    localparam state_t S_FEND = S_CSUM;
`else
    localparam state_t S_FEND = S_ISSUE;
`endif

    state_t         r_state;
    state_t         w_next;
    logic           w_acc;
    logic           w_in_frame;
    logic           w_tmo_hit;
    logic           w_err_inc;
    logic [TW-1:0]  r_tmo;
    logic           r_write;
    logic [7:0]     r_addr;
    logic [31:0]    r_wdata;
    logic [1:0]     r_idx;
    logic [7:0]     r_err_cnt;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]     r_csum;
`endif

    assign w_acc = rx_req && rx_ready;
`ifdef CMD_CHECKSUM_EN
    assign w_in_frame = (r_state == S_CMD) || (r_state == S_ADDR) ||
                        (r_state == S_DATA) || (r_state == S_CSUM);
`else
    assign w_in_frame = (r_state == S_CMD) || (r_state == S_ADDR) ||
                        (r_state == S_DATA);
`endif
    assign w_tmo_hit = w_in_frame && !w_acc && (r_tmo == TMO_MAX);

    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_err_inc = 1'b0;
        if (r_state == S_IDLE) begin
            if (w_acc && !rx_error && (rx_data == SYNC_BYTE)) begin
                w_next = S_CMD;
            end
        end else if (r_state == S_ISSUE) begin
            if (cmd_ready) begin
                w_next = S_IDLE;
            end
        end else if (w_acc) begin
            // A flagged byte aborts the frame, whatever its value.
            if (rx_error) begin
                w_next    = S_IDLE;
                w_err_inc = 1'b1;
            end else begin
                case (r_state)
                    S_CMD: begin
                        if ((rx_data == CMD_W) || (rx_data == CMD_R)) begin
                            w_next = S_ADDR;
                        end else begin
                            w_next    = S_IDLE;
                            w_err_inc = 1'b1;
                        end
                    end
                    S_ADDR: w_next = r_write ? S_DATA : S_FEND;
                    S_DATA: w_next = (r_idx == 2'd3) ? S_FEND : S_DATA;
`ifdef CMD_CHECKSUM_EN
                    S_CSUM: begin
                        if (rx_data == r_csum) begin
                            w_next = S_ISSUE;
                        end else begin
                            w_next    = S_IDLE;
                            w_err_inc = 1'b1;
                        end
                    end
`endif
                    default: w_next = S_IDLE;
                endcase
            end
        end else if (w_tmo_hit) begin
            w_next    = S_IDLE;
            w_err_inc = 1'b1;
        end
    end

    always_comb begin
        rx_ready  = (r_state != S_ISSUE);
        cmd_valid = (r_state == S_ISSUE);
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_tmo     <= '0;
            r_write   <= 1'b0;
            r_addr    <= 8'h00;
            r_wdata   <= 32'h0;
            r_idx     <= 2'd0;
            r_err_cnt <= 8'h00;
`ifdef CMD_CHECKSUM_EN
            r_csum    <= 8'h00;
`endif
        end else begin
            if (w_err_inc && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
            if (!w_in_frame || w_acc || w_tmo_hit) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (w_acc && !rx_error) begin
                case (r_state)
                    S_CMD: begin
                        r_write <= (rx_data == CMD_W);
                        r_wdata <= 32'h0;
                    end
                    S_ADDR: begin
                        r_addr <= rx_data;
                        r_idx  <= 2'd0;
                    end
                    S_DATA: begin
                        r_wdata[{r_idx, 3'b000} +: 8] <= rx_data;
                        r_idx                         <= r_idx + 2'd1;
                    end
                    default: ;
                endcase
            end
`ifdef CMD_CHECKSUM_EN
            if ((r_state == S_IDLE) && (w_next == S_CMD)) begin
                r_csum <= 8'h00;
            end else if (w_acc && !rx_error &&
                         ((r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_DATA))) begin
                r_csum <= r_csum ^ rx_data;
            end
`endif
        end
    end

    assign cmd_write = r_write;
    assign cmd_addr  = r_addr;
    assign cmd_wdata = r_wdata;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - directed self-checking bench for uart_cmd_decoder
module tb_uart_cmd_decoder;

    logic        clk = 1'b0;
    logic        reset_;
    logic        rx_req;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        rx_error;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [7:0]  err_cnt;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_cmds   = 0;
    int          n_vcyc   = 0;
    logic        last_write;
    logic [7:0]  last_addr;
    logic [31:0] last_wdata;
    logic [7:0]  tb_x;
    int          base;
    int          bad;

    always #5 clk = ~clk;

    uart_cmd_decoder #(.TIMEOUT_CYCLES(50), .SYNC_BYTE(8'hA5)) dut (
        .clk       (clk),
        .reset_    (reset_),
        .rx_req    (rx_req),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_error  (rx_error),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .err_cnt   (err_cnt)
    );

    always @(negedge clk) begin
        if (cmd_valid) n_vcyc++;
        if (cmd_valid && cmd_ready) begin
            n_cmds++;
            last_write = cmd_write;
            last_addr  = cmd_addr;
            last_wdata = cmd_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic do_reset();
        reset_    = 1'b0;
        rx_req    = 1'b0;
        rx_data   = 8'h00;
        rx_error  = 1'b0;
        cmd_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_ = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic e);
        int n = 0;
        rx_req   = 1'b1;
        rx_data  = b;
        rx_error = e;
        tb_x     = tb_x ^ b;
        @(negedge clk);
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("rx_ready_wait", 32'(n), 32'(0));
        @(posedge clk);
        #1;
        rx_req   = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic fstart();
        tb_x = 8'h00;
        send_byte(8'hA5, 1'b0);
        tb_x = 8'h00;
    endtask

    task automatic fend();
`ifdef CMD_CHECKSUM_EN
        send_byte(tb_x, 1'b0);
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tb_x = 8'h00;
        do_reset();
        check("rst_valid", 32'(cmd_valid), 32'(0));
        check("rst_write", 32'(cmd_write), 32'(0));
        check("rst_addr",  32'(cmd_addr),  32'(0));
        check("rst_wdata", cmd_wdata,      32'h0);
        check("rst_err",   32'(err_cnt),   32'(0));
        check("rst_ready", 32'(rx_ready),  32'(1));

        // Write frame, consumer always ready
        base = n_vcyc;
        fstart();
        send_byte(8'h57, 1'b0); send_byte(8'h10, 1'b0);
        send_byte(8'hEF, 1'b0); send_byte(8'hBE, 1'b0);
        send_byte(8'hAD, 1'b0); send_byte(8'hDE, 1'b0);
        fend();
        check("wr_latency", 32'(cmd_valid), 32'(1));
        idle(3);
        check("wr_pulse", 32'(n_vcyc - base), 32'(1));
        check("wr_cnt",   32'(n_cmds), 32'(1));
        check("wr_write", 32'(last_write), 32'(1));
        check("wr_addr",  32'(last_addr), 32'h10);
        check("wr_wdata", last_wdata, 32'hDEADBEEF);
        check("wr_err",   32'(err_cnt), 32'(0));

        // Read frame after noise, consumer stalls with a pending byte
        cmd_ready = 1'b0;
        send_byte(8'h00, 1'b0); send_byte(8'h33, 1'b0);
        fstart();
        send_byte(8'h52, 1'b0); send_byte(8'h04, 1'b0);
        fend();
        rx_req = 1'b1; rx_data = 8'h55; rx_error = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (rx_ready || !cmd_valid || cmd_write || cmd_addr != 8'h04 || cmd_wdata != 32'h0) bad++;
        end
        check("rd_hold", 32'(bad), 32'(0));
        check("rd_write", 32'(cmd_write), 32'(0));
        check("rd_addr",  32'(cmd_addr), 32'h04);
        check("rd_wdata", cmd_wdata, 32'h0);
        @(posedge clk); #1 cmd_ready = 1'b1;
        @(negedge clk);
        check("rd_ready_on_accept", 32'(rx_ready), 32'(0));
        @(posedge clk); #1;
        check("rd_ready_after", 32'(rx_ready), 32'(1));
        check("rd_valid_after", 32'(cmd_valid), 32'(0));
        @(posedge clk); #1 rx_req = 1'b0;
        idle(2);
        check("rd_cnt", 32'(n_cmds), 32'(2));
        check("rd_err", 32'(err_cnt), 32'(0));

        // Bad CMD, then read, then SYNC as address data
        do_reset();
        fstart(); send_byte(8'h58, 1'b0);
        idle(2);
        check("badcmd_err", 32'(err_cnt), 32'(1));
        base = n_cmds;
        fstart(); send_byte(8'h52, 1'b0); send_byte(8'h07, 1'b0); fend();
        idle(2);
        check("rd7_cnt",  32'(n_cmds - base), 32'(1));
        check("rd7_addr", 32'(last_addr), 32'h07);
        check("rd7_write", 32'(last_write), 32'(0));
        fstart(); send_byte(8'h52, 1'b0); send_byte(8'hA5, 1'b0); fend();
        idle(2);
        check("sync_as_addr", 32'(last_addr), 32'hA5);
        base = n_cmds;
        send_byte(8'hA5, 1'b1); send_byte(8'h52, 1'b0); send_byte(8'h07, 1'b0);
        idle(2);
        check("idle_err_sync_cnt", 32'(n_cmds - base), 32'(0));
        check("idle_err_sync_err", 32'(err_cnt), 32'(1));

        // Inter-byte timeout, exact boundary
        do_reset();
        fstart(); send_byte(8'h57, 1'b0);
        idle(50);
        check("tmo_before", 32'(err_cnt), 32'(0));
        idle(1);
        check("tmo_expire", 32'(err_cnt), 32'(1));
        base = n_cmds;
        fstart(); send_byte(8'h57, 1'b0);
        idle(50);
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        fend();
        idle(2);
        check("tmo_next_cnt",  32'(n_cmds - base), 32'(1));
        check("tmo_next_addr", 32'(last_addr), 32'h01);
        check("tmo_next_data", last_wdata, 32'h00000001);
        check("tmo_next_err",  32'(err_cnt), 32'(1));

        // rx_error abort, saturation, reset mid-frame
        do_reset();
        base = n_cmds;
        fstart(); send_byte(8'h57, 1'b0); send_byte(8'h10, 1'b1);
        idle(2);
        check("rxerr_err", 32'(err_cnt), 32'(1));
        check("rxerr_cnt", 32'(n_cmds - base), 32'(0));
        for (int i = 0; i < 300; i++) begin
            fstart(); send_byte(8'h00, 1'b0);
        end
        idle(2);
        check("err_sat", 32'(err_cnt), 32'hFF);
        fstart(); send_byte(8'h57, 1'b0);
        do_reset();
        check("midrst_err",   32'(err_cnt), 32'(0));
        check("midrst_valid", 32'(cmd_valid), 32'(0));
        base = n_cmds;
        fstart(); send_byte(8'h52, 1'b0); send_byte(8'h07, 1'b0); fend();
        idle(2);
        check("midrst_cnt",  32'(n_cmds - base), 32'(1));
        check("midrst_addr", 32'(last_addr), 32'h07);

`ifdef CMD_CHECKSUM_EN
        do_reset();
        base = n_cmds;
        send_byte(8'hA5, 1'b0); send_byte(8'h52, 1'b0);
        send_byte(8'h04, 1'b0); send_byte(8'h56, 1'b0);
        idle(2);
        check("csum_ok_cnt",  32'(n_cmds - base), 32'(1));
        check("csum_ok_addr", 32'(last_addr), 32'h04);
        send_byte(8'hA5, 1'b0); send_byte(8'h52, 1'b0);
        send_byte(8'h04, 1'b0); send_byte(8'h57, 1'b0);
        idle(2);
        check("csum_bad_cnt", 32'(n_cmds - base), 32'(1));
        check("csum_bad_err", 32'(err_cnt), 32'(1));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
